// File: rtl/sprite_draw_scheduler_if.sv
// rtl/sprite_draw_scheduler_if.sv - requester and VGA signal bundle for the sprite draw scheduler
interface sprite_draw_scheduler_if;
  logic [3:0]  req;
  logic [31:0] old_x;
  logic [27:0] old_y;
  logic [31:0] new_x;
  logic [27:0] new_y;
  logic [11:0] colour;
  logic [3:0]  ack;
  logic        busy;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;

  modport master (
    output req, old_x, old_y, new_x, new_y, colour,
    input  ack, busy, vga_x, vga_y, vga_colour, vga_plot
  );

  modport slave (
    input  req, old_x, old_y, new_x, new_y, colour,
    output ack, busy, vga_x, vga_y, vga_colour, vga_plot
  );
endinterface

// File: rtl/sprite_draw_scheduler.sv
// rtl/sprite_draw_scheduler.sv - round-robin erase+redraw of four sprites onto a VGA pixel port
module sprite_draw_scheduler #(
  parameter int         SPRITE_W  = 4,
  parameter int         SPRITE_H  = 4,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input logic                    clk,
  input logic                    resetn,
  sprite_draw_scheduler_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_ERASE, S_DRAW, S_ACK} state_t;

  localparam logic [2:0] COL_LAST = 3'(SPRITE_W - 1);
  localparam logic [2:0] ROW_LAST = 3'(SPRITE_H - 1);

  state_t     r_state, w_next;
  logic [2:0] r_col, r_row;
  logic [1:0] r_grant, r_last;
  logic [7:0] r_ox, r_nx;
  logic [6:0] r_oy, r_ny;
  logic [2:0] r_colour;

  logic [1:0] w_pick;
  logic       w_found;
  logic [7:0] w_ox, w_nx;
  logic [6:0] w_oy, w_ny;
  logic [2:0] w_colour;
  logic       w_scan, w_scan_end;
  logic [7:0] w_px;
  logic [6:0] w_py;

  // Search begins one past the last grant; offset 4 wraps back to the last grant itself.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_last;
    for (int k = 1; k <= 4; k++) begin
      if (!w_found && bus.req[r_last + 2'(k)]) begin
        w_found = 1'b1;
        w_pick  = r_last + 2'(k);
      end
    end
  end

  always_comb begin
    w_ox     = '0;
    w_oy     = '0;
    w_nx     = '0;
    w_ny     = '0;
    w_colour = '0;
    for (int i = 0; i < 4; i++) begin
      if (w_pick == 2'(i)) begin
        w_ox     = bus.old_x[8*i +: 8];
        w_oy     = bus.old_y[7*i +: 7];
        w_nx     = bus.new_x[8*i +: 8];
        w_ny     = bus.new_y[7*i +: 7];
        w_colour = bus.colour[3*i +: 3];
      end
    end
  end

  assign w_scan     = (r_state == S_ERASE) || (r_state == S_DRAW);
  assign w_scan_end = (r_col == COL_LAST) && (r_row == ROW_LAST);
  assign w_px       = ((r_state == S_ERASE) ? r_ox : r_nx) + {5'b0, r_col};
  assign w_py       = ((r_state == S_ERASE) ? r_oy : r_ny) + {4'b0, r_row};

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_found)    w_next = S_ERASE;
      S_ERASE: if (w_scan_end) w_next = S_DRAW;
      S_DRAW:  if (w_scan_end) w_next = S_ACK;
      default:                 w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_col    <= '0;
      r_row    <= '0;
      r_grant  <= '0;
      r_last   <= 2'd3;
      r_ox     <= '0;
      r_oy     <= '0;
      r_nx     <= '0;
      r_ny     <= '0;
      r_colour <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE) begin
        if (w_found) begin
          r_grant  <= w_pick;
          r_last   <= w_pick;
          r_ox     <= w_ox;
          r_oy     <= w_oy;
          r_nx     <= w_nx;
          r_ny     <= w_ny;
          r_colour <= w_colour;
          r_col    <= '0;
          r_row    <= '0;
        end
      end else if (w_scan) begin
        // Row-major scan; both counters fall back to zero at the end of each pass.
        if (r_col == COL_LAST) begin
          r_col <= '0;
          r_row <= (r_row == ROW_LAST) ? 3'd0 : r_row + 3'd1;
        end else begin
          r_col <= r_col + 3'd1;
        end
      end
    end
  end

  assign bus.busy       = (r_state != S_IDLE);
  assign bus.ack        = (r_state == S_ACK) ? (4'b0001 << r_grant) : 4'b0000;
  assign bus.vga_x      = w_scan ? w_px : 8'd0;
  assign bus.vga_y      = w_scan ? w_py : 7'd0;
  assign bus.vga_colour = (r_state == S_ERASE) ? BG_COLOUR :
                          (r_state == S_DRAW)  ? r_colour  : 3'd0;
  assign bus.vga_plot   = w_scan && (w_px < 8'd160) && (w_py < 7'd120);

endmodule

// File: doc/sprite_draw_scheduler.md
SPRITE_DRAW_SCHEDULER -- requirements
Module: sprite_draw_scheduler

Interface
REQ-001 Parameter SPRITE_W, default 4: sprite width in pixels, range 1..8.
REQ-002 Parameter SPRITE_H, default 4: sprite height in pixels, range 1..8.
REQ-003 Parameter BG_COLOUR, default 3'b000: colour used for erase pixels.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 resetn  in  1  reset, synchronous, active-low.
REQ-006 req  in  4  per-requester draw request; requester i holds req[i] high until it sees ack[i].
REQ-007 old_x  in  32  four 8-bit fields; field i = [8i+7:8i] = top-left x of requester i's previous sprite.
REQ-008 old_y  in  28  four 7-bit fields; field i = [7i+6:7i] = top-left y of requester i's previous sprite.
REQ-009 new_x  in  32  four 8-bit fields, same packing as old_x: top-left x of the new sprite position.
REQ-010 new_y  in  28  four 7-bit fields, same packing as old_y: top-left y of the new sprite position.
REQ-011 colour  in  12  four 3-bit fields; field i = [3i+2:3i] = sprite colour for requester i.
REQ-012 ack  out  4  one-cycle pulse on bit i when requester i's erase+draw sequence has completed.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 vga_x  out  8  pixel x coordinate to the VGA adapter.
REQ-015 vga_y  out  7  pixel y coordinate to the VGA adapter.
REQ-016 vga_colour  out  3  pixel colour to the VGA adapter.
REQ-017 vga_plot  out  1  pixel write enable to the VGA adapter.

Function
REQ-018 The FSM SHALL have four states: IDLE, ERASE, DRAW, ACK; all outputs are functions of registered state only (Moore).
REQ-019 IDLE: if any req bit is high, grant one requester round-robin, latch its old/new coordinates and colour, clear the row/column counters, and go to ERASE; otherwise stay in IDLE.
REQ-020 Round-robin: search starts at (last_grant+1) mod 4 and the first high req bit wins; after reset last_grant = 3, so requester 0 has highest priority.
REQ-021 ERASE: plot one pixel per cycle at (old_x+col, old_y+row) with BG_COLOUR, in row-major order (col fastest), SPRITE_W*SPRITE_H cycles, then go to DRAW with counters cleared.
REQ-022 DRAW: same scan at (new_x+col, new_y+row) with the latched colour, SPRITE_W*SPRITE_H cycles, then go to ACK.
REQ-023 ACK: assert ack[grant] for exactly one cycle, then return to IDLE; arbitration restarts in that IDLE cycle.
REQ-024 Latency: req sampled in cycle T gives the first plot in T+1, the last plot in T+2*W*H, ack in T+2*W*H+1, and the earliest next grant decision in T+2*W*H+2.
REQ-025 Inputs are latched only at grant; input changes during ERASE/DRAW SHALL NOT affect the sequence in progress.
REQ-026 A req dropped after grant SHALL NOT abort the sequence; ack is still pulsed.
REQ-027 Coordinate sums are 8-bit (x) and 7-bit (y) and wrap modulo width.
REQ-028 Any pixel with x > 159 or y > 119 SHALL be clipped: vga_plot = 0 for that cycle, and the cycle is still consumed.
REQ-029 In IDLE and ACK: vga_plot = 0, and vga_x/vga_y/vga_colour = 0.

Reset
REQ-030 While resetn = 0 at a clock edge: state goes to IDLE, ack = 0, busy = 0, vga_plot = 0, vga_x/vga_y/vga_colour = 0, counters = 0, last_grant = 3.
REQ-031 Reset asserted mid-ERASE or mid-DRAW SHALL abort the operation with no ack; the interrupted requester must re-request.

Verification
REQ-032 Single request: req=0001, old=(18,15), new=(19,15), colour[2:0]=3'b100 -> 16 erase plots from (18,15) to (21,18) with colour 000, then 16 draws from (19,15) to (22,18) with colour 100, ack=0001 in cycle T+33, busy low in T+34.
REQ-033 Contention: req=1111 held continuously from reset -> grant order 0,1,2,3,0; exactly one ack bit per 34-cycle window.
REQ-034 Clipping: new=(158,118), W=H=4 -> only pixels at x in {158,159} and y in {118,119} have vga_plot=1 (4 plots); DRAW still lasts 16 cycles.
REQ-035 Input change mid-op: alter new_x[0] during ERASE -> DRAW uses the value latched at grant.
REQ-036 Reset mid-DRAW: resetn=0 for one cycle at draw pixel 5 -> next cycle IDLE, vga_plot=0, no ack; a subsequent req=0100 is granted to requester 2 with normal timing.
REQ-037 Dropped request: deassert req[1] during ERASE -> ack[1] still pulses at T+33.
